// File: rtl/scene_pkg.sv
// Shared scene/state encodings for the scene sequencer and its helpers.
// Built with or without SCENE_FADE_EN; the fade states are simply unused when it is undefined.
package scene_pkg;

    localparam logic [1:0] SCENE_TITLE = 2'd0;
    localparam logic [1:0] SCENE_GAME  = 2'd1;
    localparam logic [1:0] SCENE_WIN   = 2'd2;

    localparam logic [2:0] S_TITLE    = 3'd0;
    localparam logic [2:0] S_GAME     = 3'd1;
    localparam logic [2:0] S_WIN      = 3'd2;
    localparam logic [2:0] S_FADE_OUT = 3'd3;
    localparam logic [2:0] S_FADE_IN  = 3'd4;

    localparam int V_ACTIVE_DEF = 480;

    function automatic logic [2:0] steady_of(input logic [1:0] s);
        case (s)
            SCENE_GAME: steady_of = S_GAME;
            SCENE_WIN:  steady_of = S_WIN;
            default:    steady_of = S_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/rgb_dimmer.sv
// Combinational RGB444 x 4-bit brightness scaler, zero latency, no flow control.
// Each channel becomes (c*level+7)/15, so level 15 is a pass-through and level 0 is black.
module rgb_dimmer (
    input  logic [11:0] rgb_in,
    input  logic [3:0]  level,
    output logic [11:0] rgb_out
);

    function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [3:0] l);
        logic [7:0] p;
        p        = ({4'd0, c} * {4'd0, l}) + 8'd7;
        scale_ch = 4'(p / 8'd15);
    endfunction

    always_comb begin
        rgb_out = {scale_ch(rgb_in[11:8], level),
                   scale_ch(rgb_in[7:4],  level),
                   scale_ch(rgb_in[3:0],  level)};
    end

endmodule

// File: rtl/scene_sequencer.sv
// TITLE -> GAME -> WIN -> TITLE scene controller; scene changes only on frame ticks.
// SCENE_FADE_EN adds a 16+16 frame brightness fade per change; otherwise the switch takes one tick.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int FADE_STEPS = 15,
    parameter int WIN_FRAMES = 600,
    parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        start_pulse,
    input  logic        game_won,
    input  logic [11:0] title_vga_data,
    input  logic [11:0] game_vga_data,
    input  logic [11:0] win_vga_data,
    input  logic [16:0] title_pixel_addr,
    input  logic [16:0] game_pixel_addr,
    input  logic [16:0] win_pixel_addr,
    output logic [16:0] pixel_addr,
    output logic [11:0] vga_data,
    output logic [1:0]  scene,
    output logic        game_run
);

    localparam logic [9:0] V_LINE   = 10'(V_ACTIVE);
    localparam logic [9:0] WIN_LAST = 10'(WIN_FRAMES - 1);
    localparam logic [3:0] LVL_MAX  = 4'(FADE_STEPS);

    logic       cond_q, cond_d;
    logic       tick_q, tick_d;
    logic [2:0] state_q, state_d;
    logic [1:0] shown_q, shown_d;
    logic [1:0] target_q, target_d;
    logic [3:0] level_q, level_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic       pend_q, pend_d;
    logic       req;
    logic [1:0] req_scene;
    logic [11:0] mux_rgb;
    logic [11:0] dim_rgb;

    // Edge-detect the blanking-start point: clk may be faster than the pixel clock.
    always_comb begin
        cond_d = (v_cnt == V_LINE) && (h_cnt == 10'd0);
        tick_d = cond_d && !cond_q;
    end

    always_comb begin
        req       = 1'b0;
        req_scene = target_q;
        case (state_q)
            S_TITLE: if (start_pulse) begin req = 1'b1; req_scene = SCENE_GAME; end
            S_GAME:  if (game_won)    begin req = 1'b1; req_scene = SCENE_WIN;  end
            S_WIN: begin
                if (start_pulse || (tick_q && frame_cnt_q == WIN_LAST)) begin
                    req       = 1'b1;
                    req_scene = SCENE_TITLE;
                end
            end
            default: req = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shown_d  = shown_q;
        target_d = target_q;
        level_d  = level_q;
        pend_d   = pend_q;
`ifdef SCENE_FADE_EN
        if (req) begin
            target_d = req_scene;
            state_d  = S_FADE_OUT;
        end else if (tick_q && state_q == S_FADE_OUT) begin
            if (level_q == 4'd0) begin
                shown_d = target_q;
                state_d = S_FADE_IN;
            end else begin
                level_d = level_q - 4'd1;
            end
        end else if (tick_q && state_q == S_FADE_IN) begin
            if (level_q == LVL_MAX) begin
                state_d = steady_of(shown_q);
            end else begin
                level_d = level_q + 4'd1;
            end
        end
`else
        level_d = LVL_MAX;
        // A pending switch blocks further requests until it lands on the next tick.
        if (pend_q) begin
            if (tick_q) begin
                shown_d = target_q;
                state_d = steady_of(target_q);
                pend_d  = 1'b0;
            end
        end else if (req) begin
            target_d = req_scene;
            pend_d   = 1'b1;
        end
`endif
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d == S_WIN && state_q != S_WIN) begin
            frame_cnt_d = 10'd0;
        end else if (state_q == S_WIN && tick_q && frame_cnt_q != 10'h3FF) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q      <= 1'b0;
            tick_q      <= 1'b0;
            state_q     <= S_TITLE;
            shown_q     <= SCENE_TITLE;
            target_q    <= SCENE_TITLE;
            level_q     <= LVL_MAX;
            frame_cnt_q <= 10'd0;
            pend_q      <= 1'b0;
        end else begin
            cond_q      <= cond_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            shown_q     <= shown_d;
            target_q    <= target_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        case (shown_q)
            SCENE_GAME: begin pixel_addr = game_pixel_addr; mux_rgb = game_vga_data; end
            SCENE_WIN:  begin pixel_addr = win_pixel_addr;  mux_rgb = win_vga_data;  end
            default:    begin pixel_addr = title_pixel_addr; mux_rgb = title_vga_data; end
        endcase
    end

    rgb_dimmer u_dimmer (
        .rgb_in  (mux_rgb),
        .level   (level_q),
        .rgb_out (dim_rgb)
    );

    assign vga_data = valid ? dim_rgb : 12'h000;
    assign scene    = shown_q;
    assign game_run = (state_q == S_GAME);

endmodule
